// File: rtl/dmux_pkg.sv
// Shared types and constants for the N-way stream demultiplexer.
package dmux_pkg;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  localparam int DMUX_WIDTH = 8;
  localparam int DMUX_N     = 4;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmux_n_stream_if.sv
// Upstream word/handshake plus per-channel downstream bundle of the demultiplexer.
interface dmux_n_stream_if import dmux_pkg::*; #(
  parameter int WIDTH = DMUX_WIDTH,
  parameter int N     = DMUX_N,
  parameter int SELW  = sel_w(N)
);
  logic [WIDTH-1:0]   ic;
  logic [SELW-1:0]    isel;
  logic               ibcast;
  logic               ivalid;
  logic               oready;
  logic [N*WIDTH-1:0] oz;
  logic [N-1:0]       ozvalid;
  logic [N-1:0]       iready;
  logic               oerr;

  modport master (output ic, isel, ibcast, ivalid, iready,
                  input  oready, oz, ozvalid, oerr);
  modport slave  (input  ic, isel, ibcast, ivalid, iready,
                  output oready, oz, ozvalid, oerr);
endinterface

// File: rtl/dmux_ch_buf.sv
// One-entry output buffer for a single channel; writes only arrive when can_acc is high.
module dmux_ch_buf import dmux_pkg::*; #(
  parameter int WIDTH = DMUX_WIDTH
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             iready,
  output logic             ozvalid,
  output logic [WIDTH-1:0] oz,
  output logic             can_acc
);

  ch_state_e        st_p1, st_nxt;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) st_p1 <= CH_EMPTY;
    else      st_p1 <= st_nxt;
  end

  always_comb begin
    st_nxt = st_p1;
    case (st_p1)
      CH_EMPTY: if (wr) st_nxt = CH_FULL;
      CH_FULL:  if (!wr && iready) st_nxt = CH_EMPTY;
      default:  st_nxt = CH_EMPTY;
    endcase
  end

  // Data is cleared by reset so oz reads zero while irst is held.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst)    data_p1 <= '0;
    else if (wr) data_p1 <= din;
  end

  assign ozvalid = (st_p1 == CH_FULL);
  assign oz      = data_p1;
  assign can_acc = (st_p1 == CH_EMPTY) || iready;

endmodule

// File: rtl/dmux_n_stream.sv
// Routes each upstream word to one channel (or all, on broadcast); out-of-range selects are dropped and flagged.
module dmux_n_stream import dmux_pkg::*; #(
  parameter  int WIDTH = DMUX_WIDTH,
  parameter  int N     = DMUX_N,
  localparam int SELW  = sel_w(N)
) (
  input logic             iclk,
  input logic             irst,
  dmux_n_stream_if.slave  bus
);

  logic [N-1:0]       can_acc;
  logic [N-1:0]       wr;
  logic [N-1:0]       ozvalid_w;
  logic [N*WIDTH-1:0] oz_w;
  logic [31:0]        sel_ext;
  logic               sel_ok;
  logic               uni_ok;
  logic               oready_c;
  logic               accept;
  logic               err_p1;

  // oready looks only at buffer state and iready, never at ivalid.
  always_comb begin
    sel_ext = 32'(bus.isel);
    sel_ok  = sel_ext < 32'(N);
    uni_ok  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_ext == 32'(k)) uni_ok = can_acc[k];
    end
    if (irst)            oready_c = 1'b0;
    else if (bus.ibcast) oready_c = &can_acc;
    else if (!sel_ok)    oready_c = 1'b1;
    else                 oready_c = uni_ok;
  end

  always_comb begin
    accept = bus.ivalid && oready_c;
    wr     = '0;
    for (int k = 0; k < N; k++) begin
      wr[k] = accept && (bus.ibcast || (sel_ext == 32'(k)));
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) err_p1 <= 1'b0;
    else      err_p1 <= accept && !bus.ibcast && !sel_ok;
  end

  for (genvar gk = 0; gk < N; gk++) begin : g_ch
    dmux_ch_buf #(.WIDTH(WIDTH)) u_buf (
      .iclk    (iclk),
      .irst    (irst),
      .wr      (wr[gk]),
      .din     (bus.ic),
      .iready  (bus.iready[gk]),
      .ozvalid (ozvalid_w[gk]),
      .oz      (oz_w[gk*WIDTH +: WIDTH]),
      .can_acc (can_acc[gk])
    );
  end

  assign bus.oready  = oready_c;
  assign bus.ozvalid = ozvalid_w;
  assign bus.oz      = oz_w;
  assign bus.oerr    = err_p1;

endmodule

// File: tb/tb_dmux_n_stream.sv
// Bench: directed vectors plus a cycle model and per-channel scoreboards for dmux_n_stream.
module tb_dmux_n_stream;
  import dmux_pkg::*;

  localparam int W  = 8;
  localparam int NA = 4;
  localparam int NB = 3;

  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  dmux_n_stream_if #(.WIDTH(W), .N(NA)) ba();
  dmux_n_stream_if #(.WIDTH(W), .N(NB)) bb();

  dmux_n_stream #(.WIDTH(W), .N(NA)) dut_a (.iclk(iclk), .irst(irst), .bus(ba.slave));
  dmux_n_stream #(.WIDTH(W), .N(NB)) dut_b (.iclk(iclk), .irst(irst), .bus(bb.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of channel A: what each channel must show, from the transfer rules.
  bit         m_full [NA];
  bit [W-1:0] m_data [NA];
  bit         m_err;
  bit         n_full [NA];
  bit [W-1:0] n_data [NA];
  bit         n_err;
  logic [W-1:0] sbq [NA][$];
  int         n_acc = 0;

  function automatic bit m_ready();
    bit r;
    int sv;
    r  = 1'b1;
    sv = int'(ba.isel);
    if (ba.ibcast) begin
      for (int k = 0; k < NA; k++) if (m_full[k] && !ba.iready[k]) r = 1'b0;
    end else if (sv < NA) begin
      r = !m_full[sv] || ba.iready[sv];
    end
    return r;
  endfunction

  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      for (int k = 0; k < NA; k++) begin
        m_full[k] = 1'b0; m_data[k] = '0; n_full[k] = 1'b0; n_data[k] = '0;
        sbq[k].delete();
      end
      m_err = 1'b0; n_err = 1'b0;
    end else begin
      for (int k = 0; k < NA; k++) begin
        m_full[k] = n_full[k]; m_data[k] = n_data[k];
      end
      m_err = n_err;
    end
  end

  always @(negedge iclk) begin
    bit acc;
    int sv;
    if (irst) begin
      chk("rst_ozvalid", 32'(ba.ozvalid), 32'h0);
      chk("rst_oz", 32'(ba.oz), 32'h0);
      chk("rst_oerr", 32'(ba.oerr), 32'h0);
      chk("rst_oready", 32'(ba.oready), 32'h0);
    end else begin
      for (int k = 0; k < NA; k++) begin
        chk($sformatf("ozvalid%0d", k), 32'(ba.ozvalid[k]), 32'(m_full[k]));
        if (m_full[k]) chk($sformatf("oz%0d", k), 32'(ba.oz[k*W +: W]), 32'(m_data[k]));
      end
      chk("oerr", 32'(ba.oerr), 32'(m_err));
      chk("oready", 32'(ba.oready), 32'(m_ready()));
      for (int k = 0; k < NA; k++) begin
        if (ba.ozvalid[k] && ba.iready[k]) begin
          total++;
          if (sbq[k].size() == 0) begin
            bad++;
            $display("FAIL sb_extra ch%0d actual=%0h required=none", k, ba.oz[k*W +: W]);
          end else begin
            logic [W-1:0] e;
            e = sbq[k].pop_front();
            if (ba.oz[k*W +: W] !== e) begin
              bad++;
              $display("FAIL sb_order ch%0d actual=%0h required=%0h", k, ba.oz[k*W +: W], e);
            end
          end
        end
      end
      sv  = int'(ba.isel);
      acc = ba.ivalid && m_ready();
      if (acc) n_acc++;
      for (int k = 0; k < NA; k++) begin
        if (acc && (ba.ibcast || sv == k)) begin
          n_full[k] = 1'b1; n_data[k] = ba.ic;
          sbq[k].push_back(ba.ic);
        end else begin
          n_full[k] = m_full[k] && !ba.iready[k];
          n_data[k] = m_data[k];
        end
      end
      n_err = acc && !ba.ibcast && (sv >= NA);
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic [7:0] d);
    ba.ivalid = v; ba.isel = s; ba.ibcast = b; ba.ic = d;
  endtask

  initial begin
    int base, cyc;
    irst = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 8'h5C);
    ba.iready = '0;
    bb.ivalid = 1'b0; bb.isel = '0; bb.ibcast = 1'b0; bb.ic = '0; bb.iready = '1;
    #2;
    chk("init_ozvalid", 32'(ba.ozvalid), 32'h0);
    chk("init_oz", 32'(ba.oz), 32'h0);
    chk("init_oready", 32'(ba.oready), 32'h0);
    chk("init_oerr", 32'(ba.oerr), 32'h0);
    @(posedge iclk); @(posedge iclk); #1;
    irst = 1'b0;
    ba.ivalid = 1'b0;
    tick();
    chk("lost_in_rst", 32'(ba.ozvalid), 32'h0);
    chk("lost_no_err", 32'(ba.oerr), 32'h0);

    // Unicast stream over all channels
    ba.iready = 4'hF;
    for (int i = 0; i < NA; i++) begin
      drive(1'b1, 2'(i), 1'b0, 8'(8'h11 * (i + 1)));
      #1 chk("uni_oready", 32'(ba.oready), 32'h1);
      tick();
      chk("uni_ozvalid", 32'(ba.ozvalid), 32'(1 << i));
      chk("uni_oz", 32'(ba.oz[i*W +: W]), 32'(8'h11 * (i + 1)));
    end
    ba.ivalid = 1'b0;
    tick();
    chk("uni_drained", 32'(ba.ozvalid), 32'h0);

    // Backpressure on channel 2
    ba.iready = 4'b1011;
    drive(1'b1, 2'd2, 1'b0, 8'hA5);
    #1 chk("bp_first_rdy", 32'(ba.oready), 32'h1);
    tick();
    chk("bp_hold_vld", 32'(ba.ozvalid), 32'h4);
    chk("bp_hold_oz", 32'(ba.oz[2*W +: W]), 32'hA5);
    drive(1'b1, 2'd2, 1'b0, 8'h5A);
    #1 chk("bp_blocked", 32'(ba.oready), 32'h0);
    tick();
    chk("bp_still_a5", 32'(ba.oz[2*W +: W]), 32'hA5);
    ba.isel = 2'd1;
    #1 chk("bp_other_sel", 32'(ba.oready), 32'h1);
    ba.isel = 2'd2;
    ba.iready = 4'hF;
    #1 chk("bp_released", 32'(ba.oready), 32'h1);
    tick();
    chk("bp_replaced", 32'(ba.oz[2*W +: W]), 32'h5A);
    chk("bp_replaced_vld", 32'(ba.ozvalid), 32'h4);
    ba.ivalid = 1'b0;
    tick();
    chk("bp_drained", 32'(ba.ozvalid), 32'h0);

    // Broadcast blocked by a full, stalled channel 3
    ba.iready = 4'b0111;
    drive(1'b1, 2'd3, 1'b0, 8'h77);
    tick();
    drive(1'b1, 2'd0, 1'b1, 8'hC3);
    #1 chk("bc_blocked", 32'(ba.oready), 32'h0);
    tick();
    chk("bc_no_write", 32'(ba.ozvalid), 32'h8);
    chk("bc_ch3_kept", 32'(ba.oz[3*W +: W]), 32'h77);
    ba.iready = 4'hF;
    #1 chk("bc_open", 32'(ba.oready), 32'h1);
    tick();
    chk("bc_all_vld", 32'(ba.ozvalid), 32'hF);
    chk("bc_all_oz", 32'(ba.oz), 32'hC3C3C3C3);
    ba.ivalid = 1'b0;
    tick();

    // Invalid select on the three-channel instance
    bb.ivalid = 1'b1; bb.isel = 2'd3; bb.ic = 8'hFF;
    #1 chk("inv_oready", 32'(bb.oready), 32'h1);
    tick();
    bb.ivalid = 1'b0;
    chk("inv_oerr", 32'(bb.oerr), 32'h1);
    chk("inv_no_write", 32'(bb.ozvalid), 32'h0);
    tick();
    chk("inv_oerr_pulse", 32'(bb.oerr), 32'h0);
    bb.ivalid = 1'b1; bb.isel = 2'd2; bb.ic = 8'h42; bb.iready = 3'b000;
    tick();
    bb.ivalid = 1'b0;
    chk("b_ch2_vld", 32'(bb.ozvalid), 32'h4);
    chk("b_ch2_oz", 32'(bb.oz[2*W +: W]), 32'h42);
    chk("b_ch2_no_err", 32'(bb.oerr), 32'h0);
    bb.iready = 3'b111;
    tick();

    // Asynchronous reset with channels 0 and 1 full
    ba.iready = 4'h0;
    drive(1'b1, 2'd0, 1'b0, 8'h10);
    tick();
    drive(1'b1, 2'd1, 1'b0, 8'h20);
    tick();
    chk("pre_rst_vld", 32'(ba.ozvalid), 32'h3);
    #2 irst = 1'b1;
    #1;
    chk("arst_ozvalid", 32'(ba.ozvalid), 32'h0);
    chk("arst_oz", 32'(ba.oz), 32'h0);
    chk("arst_oready", 32'(ba.oready), 32'h0);
    @(posedge iclk); #1;
    irst = 1'b0;
    ba.iready = 4'hF;
    drive(1'b1, 2'd2, 1'b0, 8'h99);
    tick();
    ba.ivalid = 1'b0;
    chk("post_rst_vld", 32'(ba.ozvalid), 32'h4);
    chk("post_rst_oz", 32'(ba.oz[2*W +: W]), 32'h99);
    tick();

    // Random traffic: model and scoreboards check every cycle
    base = n_acc;
    cyc  = 0;
    while ((n_acc - base) < 1000 && cyc < 20000) begin
      ba.ivalid = ($urandom_range(0, 3) != 0);
      ba.isel   = 2'($urandom_range(0, NA - 1));
      ba.ibcast = ($urandom_range(0, 7) == 0);
      ba.ic     = 8'($urandom);
      ba.iready = 4'($urandom);
      tick();
      cyc++;
    end
    chk("rand_words", 32'((n_acc - base) >= 1000), 32'h1);
    ba.ivalid = 1'b0;
    ba.iready = 4'hF;
    tick();
    tick();
    for (int k = 0; k < NA; k++) chk($sformatf("sb_left%0d", k), 32'(sbq[k].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
